// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Also holds the forwarding-select helper used for both ALU operands.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } md_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RES_SRC_LOAD = 2'b01;

  // The memory stage holds the younger value, so it is checked first.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m,
                                         input logic       reg_write_m,
                                         input logic [4:0] rd_w,
                                         input logic       reg_write_w);
    if (rs != 5'd0 && reg_write_m && rs == rd_m) return FWD_M;
    if (rs != 5'd0 && reg_write_w && rs == rd_w) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_tracker.sv
// Tracks the single outstanding multi-cycle mul/div op and arbitrates its
// result onto the register-file write port against the writeback stage.
module md_tracker
  import hazard_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_md_start_e,
  input  logic       i_md_done,
  input  logic [4:0] i_rd_e,
  input  logic       i_reg_write_w,
  output logic       o_md_busy,
  output logic       o_md_wb_grant,
  output logic       o_md_wb_wait,
  output logic [4:0] o_md_rd
);

  md_state_e  r_state;
  md_state_e  w_state_d;
  logic [4:0] r_md_rd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_d;
  end

  // Start requests outside IDLE and done pulses outside BUSY are ignored.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (i_md_start_e)   w_state_d = BUSY;
      BUSY:    if (i_md_done)      w_state_d = WB;
      WB:      if (!i_reg_write_w) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    o_md_busy     = (r_state != IDLE);
    o_md_wb_grant = (r_state == WB) && !i_reg_write_w;
    o_md_wb_wait  = (r_state == WB) && i_reg_write_w;
    o_md_rd       = r_md_rd;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                               r_md_rd <= 5'd0;
    else if (r_state == IDLE && i_md_start_e) r_md_rd <= i_rd_e;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and mul/div
// RAW stalls, branch flushes and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [4:0]             i_rs1_d,
  input  logic [4:0]             i_rs2_d,
  input  logic                   i_md_op_d,
  input  logic [4:0]             i_rs1_e,
  input  logic [4:0]             i_rs2_e,
  input  logic [4:0]             i_rd_e,
  input  logic [1:0]             i_res_src_e,
  input  logic                   i_reg_write_e,
  input  logic                   i_pc_src_e,
  input  logic                   i_md_start_e,
  input  logic [4:0]             i_rd_m,
  input  logic [4:0]             i_rd_w,
  input  logic                   i_reg_write_m,
  input  logic                   i_reg_write_w,
  input  logic                   i_md_done,
  output logic                   o_stall_f,
  output logic                   o_stall_d,
  output logic                   o_flush_d,
  output logic                   o_flush_e,
  output logic [1:0]             o_forward_a_e,
  output logic [1:0]             o_forward_b_e,
  output logic                   o_md_busy,
  output logic                   o_md_wb_grant,
  output logic [4:0]             o_md_rd,
  output logic [STALL_CNT_W-1:0] o_stall_count
);

  logic                   w_md_busy;
  logic                   w_md_wb_grant;
  logic                   w_md_wb_wait;
  logic [4:0]             w_md_rd;
  logic                   w_lw_stall;
  logic                   w_md_stall;
  logic                   w_stall;
  logic [STALL_CNT_W-1:0] r_stall_count;

  md_tracker u_md_tracker (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_md_start_e  (i_md_start_e),
    .i_md_done     (i_md_done),
    .i_rd_e        (i_rd_e),
    .i_reg_write_w (i_reg_write_w),
    .o_md_busy     (w_md_busy),
    .o_md_wb_grant (w_md_wb_grant),
    .o_md_wb_wait  (w_md_wb_wait),
    .o_md_rd       (w_md_rd)
  );

  // Tracker outputs are already quiet in reset; input-driven terms are gated.
  always_comb begin
    w_lw_stall = !i_rst && (i_res_src_e == RES_SRC_LOAD) && i_reg_write_e &&
                 (i_rd_e != 5'd0) && (i_rd_e == i_rs1_d || i_rd_e == i_rs2_d);
    w_md_stall = w_md_busy &&
                 (((w_md_rd != 5'd0) && (w_md_rd == i_rs1_d || w_md_rd == i_rs2_d)) ||
                  i_md_op_d);
    w_stall    = w_lw_stall || w_md_stall || w_md_wb_wait;
  end

  always_comb begin
    o_stall_f     = w_stall;
    o_stall_d     = w_stall;
    o_flush_d     = i_pc_src_e && !i_rst;
    o_flush_e     = w_lw_stall || w_md_stall || (i_pc_src_e && !i_rst);
    o_forward_a_e = i_rst ? FWD_RF :
                    fwd_sel(i_rs1_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);
    o_forward_b_e = i_rst ? FWD_RF :
                    fwd_sel(i_rs2_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);
    o_md_busy     = w_md_busy;
    o_md_wb_grant = w_md_wb_grant;
    o_md_rd       = w_md_rd;
    o_stall_count = r_stall_count;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter STALL_CNT_W, 32, width of stall performance counter.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 rs1_d, rs2_d  in  5 each  source registers of instruction in decode.
REQ-005 md_op_d  in  1  decode instruction is a multi-cycle mul/div op.
REQ-006 rs1_e, rs2_e, rd_e  in  5 each  execute-stage register fields.
REQ-007 res_src_e  in  2  execute result source; 2'b01 = load.
REQ-008 reg_write_e  in  1  execute instruction writes rd_e.
REQ-009 pc_src_e  in  1  taken branch/jump resolved in execute.
REQ-010 md_start_e  in  1  mul/div op issuing from execute this cycle.
REQ-011 rd_m, rd_w  in  5 each; reg_write_m, reg_write_w  in  1 each  memory/writeback destinations.
REQ-012 md_done  in  1  one-cycle pulse: mul/div unit result ready.
REQ-013 stall_f, stall_d, flush_d, flush_e  out  1 each  pipeline register controls.
REQ-014 forward_a_e, forward_b_e  out  2 each  ALU operand selects: 00 regfile, 01 result_w, 10 alu_result_m.
REQ-015 md_busy  out  1  mul/div unit owned by outstanding op.
REQ-016 md_wb_grant  out  1  mul/div result owns register-file write port this cycle.
REQ-017 md_rd  out  5  destination of outstanding mul/div op.
REQ-018 stall_count  out  STALL_CNT_W  cycles with stall_d asserted, saturating.

Function
REQ-019 Forwarding combinational: forward_x_e = 10 if rsx_e==rd_m, reg_write_m, rsx_e!=0; else 01 if rsx_e==rd_w, reg_write_w, rsx_e!=0; else 00; memory stage wins.
REQ-020 lw_stall = (res_src_e==01) & reg_write_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
REQ-021 md_stall = md_busy & md_rd!=0 & (md_rd==rs1_d | md_rd==rs2_d | md_rd==rd_e's consumer N/A) OR (md_busy & md_op_d).
REQ-022 stall_f = stall_d = lw_stall | md_stall | (md_wb_grant pending as per REQ-026).
REQ-023 flush_d = pc_src_e; flush_e = lw_stall | md_stall | pc_src_e; stalls/flushes combinational, same cycle.
REQ-024 FSM states IDLE, BUSY, WB; encoding in package.
REQ-025 IDLE->BUSY on md_start_e; md_rd captured <= rd_e same edge; md_busy=1 in BUSY and WB.
REQ-026 BUSY->WB on md_done; md_done in IDLE/WB ignored.
REQ-027 WB: md_wb_grant=1 only when reg_write_w==0; while reg_write_w==1 stay WB, additionally assert stall_f/stall_d so the pipeline drains one free slot next cycle.
REQ-028 WB->IDLE on edge where md_wb_grant=1; md_rd held until next capture.
REQ-029 md_start_e in BUSY/WB illegal (prevented by REQ-021); FSM ignores it.
REQ-030 md_start_e and md_done same cycle in IDLE: go BUSY, done ignored.
REQ-031 pc_src_e does not cancel an outstanding mul/div op (issued op is architecturally older).
REQ-032 stall_count increments by 1 each cycle stall_d=1; holds at all-ones.
REQ-033 md_rd==0: op still tracked, md_wb_grant still issued, no RAW stalls from it.

Reset
REQ-034 rst asserted: state IDLE, md_rd=0, stall_count=0 immediately (asynchronous), independent of clk.
REQ-035 During reset all outputs are 0; forwarding selects 00.
REQ-036 Reset mid-operation (BUSY/WB) abandons the op; no md_wb_grant after deassertion.
REQ-037 First active edge after rst deassertion behaves as in IDLE.

Structure
REQ-038 Shared package holds FSM state type (IDLE/BUSY/WB), forwarding select constants (FWD_RF, FWD_W, FWD_M) and RES_SRC_LOAD=2'b01.
REQ-039 One sub-module md_tracker: FSM, md_rd register, md_wb_grant; forwarding, stall logic and counter stay top-level.

Verification
REQ-040 Load x5 in E, decode add x6,x5,x1 -> stall_f=stall_d=flush_e=1 one cycle; next cycle forward_a_e=01.
REQ-041 add x3 in M and x3 in W, E reads rs1=x3 -> forward_a_e=10; rs1=x0 with rd_m=0 -> 00.
REQ-042 md_start_e rd_e=x7, decode reads x7 -> stall until md_done+grant; md_busy 1, md_rd=7; stall drops cycle after grant.
REQ-043 md_done while reg_write_w=1 for 2 cycles -> FSM stays WB, grant on 3rd cycle, then IDLE.
REQ-044 pc_src_e=1 with lw_stall=1 -> flush_d=1, flush_e=1; outstanding mul/div unaffected.
REQ-045 rst asserted in BUSY -> state IDLE, md_busy=0, stall_count=0 without clock edge; later md_done causes no grant.
